// File: rtl/ps2kb_scancode_translator.sv
// PS/2 Set-2 to XT Set-1 scancode translator with prefix FSM and output queue.
// Latency: one negedge register stage; backpressure by scancode_ack pop, overflow drops whole codes.
module ps2kb_scancode_translator #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    input  logic       ps2_error,
    input  logic       clear,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    input  logic       scancode_ack,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic           overflow_q;

    logic [1:0]     push_n;
    logic [7:0]     push0, push1, xlat, code;
    logic           is_ext, is_brk, pop, push_ok, ovf_evt;
    logic [CW-1:0]  free;

    function automatic logic [7:0] set2_to_set1(input logic [7:0] c);
        case (c)
            8'h01: return 8'h43; 8'h03: return 8'h3F; 8'h04: return 8'h3D; 8'h05: return 8'h3B;
            8'h06: return 8'h3C; 8'h07: return 8'h58; 8'h09: return 8'h44; 8'h0A: return 8'h42;
            8'h0B: return 8'h40; 8'h0C: return 8'h3E; 8'h0D: return 8'h0F; 8'h0E: return 8'h29;
            8'h11: return 8'h38; 8'h12: return 8'h2A; 8'h14: return 8'h1D; 8'h15: return 8'h10;
            8'h16: return 8'h02; 8'h1A: return 8'h2C; 8'h1B: return 8'h1F; 8'h1C: return 8'h1E;
            8'h1D: return 8'h11; 8'h1E: return 8'h03; 8'h1F: return 8'h5B; 8'h21: return 8'h2E;
            8'h22: return 8'h2D; 8'h23: return 8'h20; 8'h24: return 8'h12; 8'h25: return 8'h05;
            8'h26: return 8'h04; 8'h27: return 8'h5C; 8'h29: return 8'h39; 8'h2A: return 8'h2F;
            8'h2B: return 8'h21; 8'h2C: return 8'h14; 8'h2D: return 8'h13; 8'h2E: return 8'h06;
            8'h2F: return 8'h5D; 8'h31: return 8'h31; 8'h32: return 8'h30; 8'h33: return 8'h23;
            8'h34: return 8'h22; 8'h35: return 8'h15; 8'h36: return 8'h07; 8'h3A: return 8'h32;
            8'h3B: return 8'h24; 8'h3C: return 8'h16; 8'h3D: return 8'h08; 8'h3E: return 8'h09;
            8'h41: return 8'h33; 8'h42: return 8'h25; 8'h43: return 8'h17; 8'h44: return 8'h18;
            8'h45: return 8'h0B; 8'h46: return 8'h0A; 8'h49: return 8'h34; 8'h4A: return 8'h35;
            8'h4B: return 8'h26; 8'h4C: return 8'h27; 8'h4D: return 8'h19; 8'h4E: return 8'h0C;
            8'h52: return 8'h28; 8'h54: return 8'h1A; 8'h55: return 8'h0D; 8'h58: return 8'h3A;
            8'h59: return 8'h36; 8'h5A: return 8'h1C; 8'h5B: return 8'h1B; 8'h5D: return 8'h2B;
            8'h61: return 8'h56; 8'h66: return 8'h0E; 8'h69: return 8'h4F; 8'h6B: return 8'h4B;
            8'h6C: return 8'h47; 8'h70: return 8'h52; 8'h71: return 8'h53; 8'h72: return 8'h50;
            8'h73: return 8'h4C; 8'h74: return 8'h4D; 8'h75: return 8'h48; 8'h76: return 8'h01;
            8'h77: return 8'h45; 8'h78: return 8'h57; 8'h79: return 8'h4E; 8'h7A: return 8'h51;
            8'h7B: return 8'h4A; 8'h7C: return 8'h37; 8'h7D: return 8'h49; 8'h7E: return 8'h46;
            8'h83: return 8'h41;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        push_n  = 2'd0;
        push0   = 8'h00;
        push1   = 8'h00;
        xlat    = set2_to_set1(ps2_byte);
        is_ext  = (state_q == S_EXT) || (state_q == S_EXT_BREAK);
        is_brk  = (state_q == S_BREAK) || (state_q == S_EXT_BREAK);
        code    = xlat | (is_brk ? 8'h80 : 8'h00);
        if (ps2_error) begin
            state_d = S_IDLE;
        end else if (ps2_byte_valid) begin
            if (ps2_byte == 8'hE1) begin
                state_d = state_q;
            end else if (ps2_byte == 8'hF0 && state_q == S_IDLE) begin
                state_d = S_BREAK;
            end else if (ps2_byte == 8'hF0 && state_q == S_EXT) begin
                state_d = S_EXT_BREAK;
            end else if (ps2_byte == 8'hF0) begin
                state_d = state_q;
            end else if (ps2_byte == 8'hE0 && state_q == S_IDLE) begin
                state_d = S_EXT;
            end else begin
                state_d = S_IDLE;
                if (state_q == S_IDLE && ps2_byte == 8'hAA) begin
                    push_n = 2'd1;
                    push0  = 8'hAA;
                end else if (xlat != 8'h00) begin
                    // Extended fake shifts wrap PrtSc/Ins etc. and carry no key meaning
                    if (is_ext) begin
                        if (ps2_byte != 8'h12 && ps2_byte != 8'h59) begin
                            push_n = 2'd2;
                            push0  = 8'hE0;
                            push1  = code;
                        end
                    end else begin
                        push_n = 2'd1;
                        push0  = code;
                    end
                end
            end
        end
    end

    // Space is judged after a concurrent pop so a full queue can stream
    assign pop     = scancode_ack && (count_q != '0);
    assign free    = DEPTH_C - count_q + CW'(pop);
    assign push_ok = (push_n != 2'd0) && (CW'(push_n) <= free);
    assign ovf_evt = (push_n != 2'd0) && !push_ok;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PW'(push_n);
            count_q <= count_q + (push_ok ? CW'(push_n) : '0) - CW'(pop);
            if (ovf_evt)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(negedge clock) begin
        if (!reset && !clear && push_ok) begin
            mem_q[wr_ptr_q] <= push0;
            if (push_n == 2'd2)
                mem_q[wr_ptr_q + 1'b1] <= push1;
        end
    end

    assign scancode_valid = (count_q != '0);
    assign scancode       = scancode_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_full      = (count_q == DEPTH_C);
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_ps2kb_scancode_translator.sv
// Directed bench for the Set-2 to Set-1 translator; inputs change and outputs are sampled on posedge.
module tb_ps2kb_scancode_translator;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid, ps2_error, clear, scancode_ack;
    logic [7:0] scancode;
    logic       scancode_valid, fifo_full, overflow;
    int total = 0;
    int bad   = 0;

    ps2kb_scancode_translator #(.FIFO_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
        .ps2_error(ps2_error), .clear(clear), .scancode(scancode), .scancode_valid(scancode_valid),
        .scancode_ack(scancode_ack), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; the DUT samples on the negedge in between.
    task automatic cyc(input logic [7:0] b, input logic v, input logic e, input logic c, input logic a);
        ps2_byte = b; ps2_byte_valid = v; ps2_error = e; clear = c; scancode_ack = a;
        @(posedge clock);
        ps2_byte = 8'h00; ps2_byte_valid = 1'b0; ps2_error = 1'b0; clear = 1'b0; scancode_ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(b, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_exp(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, {7'd0, scancode_valid}, 8'h01);
        chk(tag, scancode, exp);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_vld"}, {7'd0, scancode_valid}, 8'h00);
        chk({tag, "_code"}, scancode, 8'h00);
    endtask

    initial begin
        reset = 1'b1; ps2_byte = 8'h00; ps2_byte_valid = 1'b0;
        ps2_error = 1'b0; clear = 1'b0; scancode_ack = 1'b0;
        @(posedge clock); @(posedge clock);
        chk_empty("reset");
        chk("reset_full", {7'd0, fifo_full}, 8'h00);
        chk("reset_ovf", {7'd0, overflow}, 8'h00);
        reset = 1'b0;
        @(posedge clock);

        // Make then break of A; first result one cycle after strobe
        send(8'h1C);
        chk("lat_vld", {7'd0, scancode_valid}, 8'h01);
        chk("lat_code", scancode, 8'h1E);
        send(8'hF0); send(8'h1C);
        pop_exp("a_make", 8'h1E);
        pop_exp("a_break", 8'h9E);
        chk_empty("a_done");
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_empty("ack_empty");

        // Extended make/break pairs and discarded fake shift
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h59);
        pop_exp("up_pfx", 8'hE0);
        pop_exp("up_make", 8'h48);
        pop_exp("upb_pfx", 8'hE0);
        pop_exp("upb_break", 8'hC8);
        chk_empty("fake_shift");

        // Error drops prefix, AA passes, FA/E1 handling, F7 special case
        send(8'hF0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h1C);
        send(8'hAA);
        send(8'hFA);
        send(8'hF0); send(8'hE1); send(8'hF0); send(8'h1C);
        send(8'h83);
        send(8'hF0); send(8'h83);
        pop_exp("err_make", 8'h1E);
        pop_exp("bat_ok", 8'hAA);
        pop_exp("e1_break", 8'h9E);
        pop_exp("f7_make", 8'h41);
        pop_exp("f7_break", 8'hC1);
        chk_empty("fa_drop");

        // Error coincident with a byte discards the byte
        cyc(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_empty("err_byte");

        // Seven entries, pair does not fit, single still fits
        for (int i = 0; i < 7; i++) send(8'h1C);
        chk("seven_full", {7'd0, fifo_full}, 8'h00);
        send(8'hE0); send(8'h75);
        chk("pair_ovf", {7'd0, overflow}, 8'h01);
        chk("pair_nofull", {7'd0, fifo_full}, 8'h00);
        send(8'h29);
        chk("eight_full", {7'd0, fifo_full}, 8'h01);
        chk("ovf_sticky", {7'd0, overflow}, 8'h01);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_empty("clear");
        chk("clear_full", {7'd0, fifo_full}, 8'h00);
        chk("clear_ovf", {7'd0, overflow}, 8'h00);

        // Full queue with simultaneous pop and push
        send(8'h16);
        for (int i = 0; i < 7; i++) send(8'h1C);
        chk("fill_full", {7'd0, fifo_full}, 8'h01);
        chk("fill_head", scancode, 8'h02);
        cyc(8'h29, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("stream_full", {7'd0, fifo_full}, 8'h01);
        chk("stream_ovf", {7'd0, overflow}, 8'h00);
        for (int i = 0; i < 7; i++) pop_exp("stream_mid", 8'h1E);
        pop_exp("stream_tail", 8'h39);
        chk_empty("stream_done");

        // Clear wins over a concurrent push
        cyc(8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_empty("clear_push");

        // Reset mid-prefix discards E0 F0
        send(8'hE0); send(8'hF0);
        reset = 1'b1;
        @(posedge clock);
        reset = 1'b0;
        @(posedge clock);
        send(8'h5A);
        pop_exp("rst_prefix", 8'h1C);
        chk_empty("rst_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
